simt_pc: RTL and testbench

SIMT_PC -- requirements
Module: simt_pc

---
 rtl/pc_pkg.sv | 22 ++
 rtl/simt_pc_if.sv | 57 +++++
 rtl/reconv_stack.sv | 48 ++++
 rtl/simt_pc.sv | 182 ++++++++++++++++++
 tb/tb_simt_pc.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared constants and stack-entry type for the SIMT program counter.
// Entry fields are sized for the widest supported mask/PC.
package pc_pkg;

  localparam logic [2:0] CS_EXECUTE = 3'b101;
  localparam logic [2:0] CS_UPDATE  = 3'b110;

  localparam int MASK_W = 32;
  localparam int PC_W   = 32;

  typedef struct packed {
    logic [MASK_W-1:0] orig_mask;
    logic [MASK_W-1:0] alt_mask;
    logic [PC_W-1:0]   alt_pc;
    logic              phase;
  } stack_entry_t;

  function automatic int depth_bits(int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/simt_pc_if.sv
// Decode-side bundle feeding the SIMT PC and its visible state.
// master = core/decoder side, slave = simt_pc.
interface simt_pc_if #(
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int STACK_DEPTH           = 4
);
  import pc_pkg::*;

  localparam int DW  = DATA_MEM_DATA_BITS;
  localparam int AW  = PROGRAM_MEM_ADDR_BITS;
  localparam int T   = THREADS_PER_BLOCK;
  localparam int SDW = depth_bits(STACK_DEPTH);

  logic [2:0]     core_state;
  logic [2:0]     decoded_nzp;
  logic [DW-1:0]  decoded_immediate;
  logic           decoded_pc_mux;
  logic           decoded_sync;
  logic [3*T-1:0] nzp;

  logic [T-1:0]   thread_mask;
  logic [AW-1:0]  current_pc;
  logic [AW-1:0]  next_pc;
  logic [SDW-1:0] stack_depth;
  logic           stack_overflow;

  modport master (
    output core_state,
    output decoded_nzp,
    output decoded_immediate,
    output decoded_pc_mux,
    output decoded_sync,
    output nzp,
    input  thread_mask,
    input  current_pc,
    input  next_pc,
    input  stack_depth,
    input  stack_overflow
  );

  modport slave (
    input  core_state,
    input  decoded_nzp,
    input  decoded_immediate,
    input  decoded_pc_mux,
    input  decoded_sync,
    input  nzp,
    output thread_mask,
    output current_pc,
    output next_pc,
    output stack_depth,
    output stack_overflow
  );

endinterface

// File: rtl/reconv_stack.sv
// Reconvergence stack: push, pop and top-phase set, one op per cycle.
// Push has priority over pop, pop over phase write.
module reconv_stack
  import pc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int DW    = depth_bits(DEPTH),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         wr_phase,
  input  stack_entry_t push_entry,
  output stack_entry_t top_entry,
  output logic         full,
  output logic         empty,
  output logic [DW-1:0] depth
);

  stack_entry_t   mem [2**IW];
  logic [DW-1:0]  cnt;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  push_idx;

  assign top_idx  = IW'(cnt - DW'(1));
  assign push_idx = IW'(cnt);
  assign full     = (cnt == DW'(DEPTH));
  assign empty    = (cnt == '0);
  assign depth    = cnt;

  assign top_entry = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (push && !full) begin
      mem[push_idx] <= push_entry;
      cnt           <= cnt + DW'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - DW'(1);
    end else if (wr_phase && !empty) begin
      mem[top_idx].phase <= 1'b1;
    end
  end

endmodule

// File: rtl/simt_pc.sv
// SIMT program counter with branch divergence and SYNC reconvergence.
// Divergence support is built only when SIMT_PC_DIVERGENCE_EN is defined.
module simt_pc
  import pc_pkg::*;
#(
  parameter int DATA_MEM_DATA_BITS    = 8,
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int STACK_DEPTH           = 4
) (
  input logic      clk,
  input logic      reset,
  simt_pc_if.slave bus
);

  localparam int AW  = PROGRAM_MEM_ADDR_BITS;
  localparam int T   = THREADS_PER_BLOCK;
  localparam int SDW = depth_bits(STACK_DEPTH);

  logic [AW-1:0] current_pc;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] pc_plus1;
  logic [AW-1:0] target;
  logic [AW-1:0] n_pc;
  logic          exec;
  logic          update;

  assign exec     = (bus.core_state == CS_EXECUTE);
  assign update   = (bus.core_state == CS_UPDATE);
  assign pc_plus1 = current_pc + AW'(1);
  assign target   = AW'(bus.decoded_immediate);

`ifdef SIMT_PC_DIVERGENCE_EN

  logic [T-1:0]   thread_mask;
  logic [T-1:0]   pend_mask;
  logic [T-1:0]   n_pend;
  logic [T-1:0]   taken;
  logic [T-1:0]   active;
  logic           stack_overflow;
  logic           n_ovf;
  logic           lead_taken;
  logic           is_br;
  logic           is_sync;
  logic           push;
  logic           pop;
  logic           wr_phase;
  logic           full;
  logic           empty;
  logic [SDW-1:0] depth;
  stack_entry_t   push_e;
  stack_entry_t   top_e;
  logic           unused_top;

  always_comb begin
    taken = '0;
    for (int i = 0; i < T; i++)
      taken[i] = |(bus.nzp[3*i +: 3] & bus.decoded_nzp);
  end

  assign active  = taken & thread_mask;
  assign is_br   = bus.decoded_pc_mux;
  assign is_sync = bus.decoded_sync & ~bus.decoded_pc_mux;

  // Overflowed divergence follows the lowest-index active thread
  always_comb begin
    lead_taken = 1'b0;
    for (int i = T - 1; i >= 0; i--)
      if (thread_mask[i]) lead_taken = taken[i];
  end

  always_comb begin
    n_pc     = pc_plus1;
    n_pend   = thread_mask;
    n_ovf    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    wr_phase = 1'b0;
    push_e   = '0;
    push_e.orig_mask = MASK_W'(thread_mask);
    push_e.alt_mask  = MASK_W'(thread_mask & ~taken);
    push_e.alt_pc    = PC_W'(pc_plus1);
    unique case (1'b1)
      is_br: begin
        if (active == thread_mask) begin
          n_pc = target;
        end else if (active != '0) begin
          if (!full) begin
            push   = exec;
            n_pend = active;
            n_pc   = target;
          end else begin
            n_ovf = 1'b1;
            n_pc  = lead_taken ? target : pc_plus1;
          end
        end
      end
      is_sync: begin
        if (!empty) begin
          if (!top_e.phase) begin
            n_pc     = AW'(top_e.alt_pc);
            n_pend   = T'(top_e.alt_mask);
            wr_phase = exec;
          end else begin
            pop    = exec;
            n_pend = T'(top_e.orig_mask);
          end
        end
      end
      default: ;
    endcase
  end

  assign unused_top = ^top_e;

  reconv_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .wr_phase   (wr_phase),
    .push_entry (push_e),
    .top_entry  (top_e),
    .full       (full),
    .empty      (empty),
    .depth      (depth)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      current_pc     <= '0;
      next_pc        <= '0;
      thread_mask    <= '1;
      pend_mask      <= '1;
      stack_overflow <= 1'b0;
    end else if (exec) begin
      next_pc   <= n_pc;
      pend_mask <= n_pend;
      if (n_ovf) stack_overflow <= 1'b1;
    end else if (update) begin
      current_pc  <= next_pc;
      thread_mask <= pend_mask;
    end
  end

  assign bus.stack_depth    = depth;
  assign bus.stack_overflow = stack_overflow;

`else

  logic [T-1:0] thread_mask;
  logic         taken0;
  logic         unused_in;

  assign thread_mask = '1;
  assign taken0      = |(bus.nzp[2:0] & bus.decoded_nzp);
  assign n_pc        = (bus.decoded_pc_mux && taken0) ? target : pc_plus1;
  assign unused_in   = ^{bus.nzp, bus.decoded_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      current_pc <= '0;
      next_pc    <= '0;
    end else if (exec) begin
      next_pc <= n_pc;
    end else if (update) begin
      current_pc <= next_pc;
    end
  end

  assign bus.stack_depth    = '0;
  assign bus.stack_overflow = 1'b0;

`endif

  assign bus.thread_mask = thread_mask;
  assign bus.current_pc  = current_pc;
  assign bus.next_pc     = next_pc;

endmodule

// File: tb/tb_simt_pc.sv
// Bench for simt_pc: vector table plus divergence/reset/overflow runs.
// Expectations follow whether SIMT_PC_DIVERGENCE_EN is defined.
module tb_simt_pc;

`ifdef SIMT_PC_DIVERGENCE_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  localparam logic [2:0] EXE = 3'b101;
  localparam logic [2:0] UPD = 3'b110;

  localparam logic [11:0] ALLZ  = 12'b010_010_010_010;
  localparam logic [11:0] ALLN  = 12'b100_100_100_100;
  localparam logic [11:0] Z01   = 12'b001_001_010_010;
  localparam logic [11:0] Z0    = 12'b001_001_001_010;
  localparam logic [11:0] P0    = 12'b010_010_010_001;

  typedef struct {
    string      name;
    bit         mux;
    bit         sync;
    logic [2:0] dnzp;
    logic [7:0] imm;
    logic [11:0] nzp;
    int         pc;
    int         mask;
    int         depth;
    int         ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  simt_pc_if #(.STACK_DEPTH(4)) bus0 ();
  simt_pc_if #(.STACK_DEPTH(1)) bus1 ();

  simt_pc #(.STACK_DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  simt_pc #(.STACK_DEPTH(1)) u_ovf (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   last_pc [2];
  int   last_mask [2];
  vec_t exp_q [$];
  vec_t tbl [15];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input bit mux, input bit sync,
    input logic [2:0] dnzp, input logic [7:0] imm,
    input logic [11:0] nzp, input int pc, input int mask,
    input int depth, input int ovf);
    vec_t v;
    v.name = nm; v.mux = mux; v.sync = sync;
    v.dnzp = dnzp; v.imm = imm; v.nzp = nzp;
    v.pc = pc; v.mask = mask; v.depth = depth; v.ovf = ovf;
    return v;
  endfunction

  task automatic drv(input int sel, input logic [2:0] cs,
                     input vec_t v);
    if (sel == 0) begin
      bus0.core_state        = cs;
      bus0.decoded_pc_mux    = v.mux;
      bus0.decoded_sync      = v.sync;
      bus0.decoded_nzp       = v.dnzp;
      bus0.decoded_immediate = v.imm;
      bus0.nzp               = v.nzp;
    end else begin
      bus1.core_state        = cs;
      bus1.decoded_pc_mux    = v.mux;
      bus1.decoded_sync      = v.sync;
      bus1.decoded_nzp       = v.dnzp;
      bus1.decoded_immediate = v.imm;
      bus1.nzp               = v.nzp;
    end
  endtask

  task automatic set_cs(input int sel, input logic [2:0] cs);
    if (sel == 0) bus0.core_state = cs;
    else          bus1.core_state = cs;
  endtask

  task automatic rd(input int sel, output int pc, output int npc,
                    output int mask, output int depth,
                    output int ovf);
    if (sel == 0) begin
      pc = int'(bus0.current_pc); npc = int'(bus0.next_pc);
      mask = int'(bus0.thread_mask);
      depth = int'(bus0.stack_depth);
      ovf = int'(bus0.stack_overflow);
    end else begin
      pc = int'(bus1.current_pc); npc = int'(bus1.next_pc);
      mask = int'(bus1.thread_mask);
      depth = int'(bus1.stack_depth);
      ovf = int'(bus1.stack_overflow);
    end
  endtask

  task automatic check_reset(input int sel, input string nm);
    int pc, npc, mask, depth, ovf;
    rd(sel, pc, npc, mask, depth, ovf);
    check({nm, ".pc"}, pc, 0);
    check({nm, ".next_pc"}, npc, 0);
    check({nm, ".mask"}, mask, 15);
    check({nm, ".depth"}, depth, 0);
    check({nm, ".ovf"}, ovf, 0);
    last_pc[sel] = 0;
    last_mask[sel] = 15;
  endtask

  task automatic step(input int sel, input vec_t v);
    int pc, npc, mask, depth, ovf;
    vec_t e;
    @(negedge clk);
    drv(sel, EXE, v);
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    rd(sel, pc, npc, mask, depth, ovf);
    check({v.name, ".next_pc"}, npc, v.pc);
    check({v.name, ".pc_hold"}, pc, last_pc[sel]);
    check({v.name, ".mask_hold"}, mask, last_mask[sel]);
    check({v.name, ".depth_exe"}, depth, v.depth);
    set_cs(sel, UPD);
    @(posedge clk);
    @(negedge clk);
    set_cs(sel, 3'b000);
    rd(sel, pc, npc, mask, depth, ovf);
    if (exp_q.size() == 0) begin
      check({v.name, ".queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({e.name, ".pc"}, pc, e.pc);
      check({e.name, ".mask"}, mask, e.mask);
      check({e.name, ".depth"}, depth, e.depth);
      check({e.name, ".ovf"}, ovf, e.ovf);
      last_pc[sel] = e.pc;
      last_mask[sel] = e.mask;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int pc, npc, mask, depth, ovf;
    vec_t nop;
    nop = mk("nop", 0, 0, 3'b000, 8'd0, 12'd0, 0, 0, 0, 0);
    drv(0, 3'b000, nop);
    drv(1, 3'b000, nop);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset(0, "rst0");
    check_reset(1, "rst1");

    tbl[0]  = mk("t00", 0, 0, 3'b000, 8'd0, ALLZ, 1, 15, 0, 0);
    tbl[1]  = mk("t01", 0, 0, 3'b000, 8'd0, ALLZ, 2, 15, 0, 0);
    tbl[2]  = mk("t02", 0, 0, 3'b000, 8'd0, ALLZ, 3, 15, 0, 0);
    tbl[3]  = mk("t03", 1, 0, 3'b111, 8'd5, ALLZ, 5, 15, 0, 0);
    tbl[4]  = mk("t04", 1, 0, 3'b010, 8'd20, ALLZ, 20, 15, 0, 0);
    tbl[5]  = mk("t05", 1, 0, 3'b111, 8'd5, ALLZ, 5, 15, 0, 0);
    tbl[6]  = mk("t06", 1, 0, 3'b010, 8'd20, Z01, 20,
                 DIV ? 3 : 15, DIV ? 1 : 0, 0);
    tbl[7]  = mk("t07", 1, 1, 3'b010, 8'd24, ALLZ, 24,
                 DIV ? 3 : 15, DIV ? 1 : 0, 0);
    tbl[8]  = mk("t08", 0, 1, 3'b000, 8'd0, ALLZ, DIV ? 6 : 25,
                 DIV ? 12 : 15, DIV ? 1 : 0, 0);
    tbl[9]  = mk("t09", 1, 0, 3'b001, 8'd24, Z01, DIV ? 24 : 26,
                 DIV ? 12 : 15, DIV ? 1 : 0, 0);
    tbl[10] = mk("t10", 0, 1, 3'b000, 8'd0, ALLZ, DIV ? 25 : 27,
                 15, 0, 0);
    tbl[11] = mk("t11", 0, 1, 3'b000, 8'd0, ALLZ, DIV ? 26 : 28,
                 15, 0, 0);
    tbl[12] = mk("t12", 1, 0, 3'b100, 8'd255, ALLN, 255, 15, 0, 0);
    tbl[13] = mk("t13", 0, 0, 3'b000, 8'd0, ALLZ, 0, 15, 0, 0);
    tbl[14] = mk("t14", 1, 0, 3'b100, 8'd40, ALLZ, 1, 15, 0, 0);

    for (int i = 0; i < 15; i++) step(0, tbl[i]);

    // Non-EXECUTE/UPDATE states must leave everything untouched
    @(negedge clk);
    drv(0, 3'b000, mk("idle", 1, 0, 3'b111, 8'd77, ALLZ,
                      0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_cs(0, 3'b011);
    @(posedge clk);
    @(negedge clk);
    set_cs(0, 3'b100);
    @(posedge clk);
    @(negedge clk);
    set_cs(0, 3'b000);
    rd(0, pc, npc, mask, depth, ovf);
    check("idle.pc", pc, 1);
    check("idle.next_pc", npc, 1);
    check("idle.mask", mask, 15);
    check("idle.depth", depth, 0);

    step(0, mk("d0", 1, 0, 3'b111, 8'd5, ALLZ, 5, 15, 0, 0));
    step(0, mk("d1", 1, 0, 3'b010, 8'd20, Z01, 20,
               DIV ? 3 : 15, DIV ? 1 : 0, 0));
    step(0, mk("d2", 1, 0, 3'b010, 8'd30, Z0, 30,
               DIV ? 1 : 15, DIV ? 2 : 0, 0));

    @(negedge clk);
    drv(0, EXE, mk("rstx", 0, 1, 3'b000, 8'd9, ALLZ,
                   0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_cs(0, 3'b000);
    check_reset(0, "rst_mid");
    check_reset(1, "rst_mid1");

    step(1, mk("o0", 1, 0, 3'b111, 8'd5, ALLZ, 5, 15, 0, 0));
    step(1, mk("o1", 1, 0, 3'b010, 8'd20, Z01, 20,
               DIV ? 3 : 15, DIV ? 1 : 0, 0));
    step(1, mk("o2", 1, 0, 3'b010, 8'd40, P0, 21,
               DIV ? 3 : 15, DIV ? 1 : 0, DIV ? 1 : 0));
    step(1, mk("o3", 0, 0, 3'b000, 8'd0, ALLZ, 22,
               DIV ? 3 : 15, DIV ? 1 : 0, DIV ? 1 : 0));

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_reset(1, "rst_ovf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
